// File: rtl/video_pattern_gen.sv
// Video timing (DE/HSYNC/VSYNC) and test-pattern generator in the pixel clock domain.
module video_pattern_gen #(
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned H_FP       = 40,
  parameter int unsigned H_SYNC     = 128,
  parameter int unsigned H_BP       = 88,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 1,
  parameter int unsigned V_SYNC     = 3,
  parameter int unsigned V_BP       = 21,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned COLOR_W    = 8,
  parameter int unsigned CHECK_LOG2 = 5,
  parameter int unsigned CNT_W      = 12
) (
  input  logic                   clk_in,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  output logic [3*COLOR_W-1:0]   vid_data,
  output logic                   vid_de,
  output logic                   vid_hsync,
  output logic                   vid_vsync,
  output logic                   frame_start
);

  localparam int unsigned PIX_W   = 3 * COLOR_W;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned BAR_W   = H_ACTIVE / 8;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [PIX_W-1:0] solid_q, solid_d;
  logic [PIX_W-1:0] vid_data_q, vid_data_d;
  logic             vid_de_q, vid_de_d;
  logic             vid_hsync_q, vid_hsync_d;
  logic             vid_vsync_q, vid_vsync_d;
  logic             frame_start_q, frame_start_d;

  logic             at_origin;
  logic             active;
  logic             hs_on;
  logic             vs_on;
  logic [2:0]       bar_idx;
  logic [2:0]       bar_bgr;
  logic [COLOR_W-1:0] ramp;
  logic [PIX_W-1:0] pattern;

  assign at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);

  // Raster counters: h wraps at H_TOTAL, v steps on h wrap; both held at 0 while idle.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!enable) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
    end else begin
      h_cnt_d = h_cnt_q + CNT_W'(1);
    end
  end

  // Mode/colour latch at frame origin; the _d value is the effective setting for this pixel.
  always_comb begin
    mode_d  = mode_q;
    solid_d = solid_q;
    if (enable && at_origin) begin
      mode_d  = mode;
      solid_d = solid_rgb;
    end
  end

  // Colour-bar index by threshold compare; remainder pixels fall into bar 7.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h_cnt_q >= CNT_W'(k * BAR_W)) bar_idx = 3'(k);
    end
  end

  // Bar colour as {b,g,r} on/off bits: white, yellow, cyan, green, magenta, red, blue, black.
  always_comb begin
    bar_bgr = 3'b000;
    case (bar_idx)
      3'd0:    bar_bgr = 3'b111;
      3'd1:    bar_bgr = 3'b011;
      3'd2:    bar_bgr = 3'b110;
      3'd3:    bar_bgr = 3'b010;
      3'd4:    bar_bgr = 3'b101;
      3'd5:    bar_bgr = 3'b001;
      3'd6:    bar_bgr = 3'b100;
      default: bar_bgr = 3'b000;
    endcase
  end

  assign ramp = COLOR_W'(h_cnt_q);

  // Pattern select for the current raster position.
  always_comb begin
    pattern = '0;
    case (mode_d)
      2'd0: pattern = {{COLOR_W{bar_bgr[2]}}, {COLOR_W{bar_bgr[1]}}, {COLOR_W{bar_bgr[0]}}};
      2'd1: pattern = {ramp, ramp, ramp};
      2'd2: pattern = (h_cnt_q[CHECK_LOG2] ^ v_cnt_q[CHECK_LOG2]) ? '1 : '0;
      default: pattern = solid_d;
    endcase
  end

  // Timing decode and next output values; idle values whenever enable is low.
  always_comb begin
    active        = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_on         = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    vs_on         = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
    vid_de_d      = enable && active;
    vid_hsync_d   = (enable && hs_on) ? HS_POL : ~HS_POL;
    vid_vsync_d   = (enable && vs_on) ? VS_POL : ~VS_POL;
    frame_start_d = enable && at_origin && active;
    vid_data_d    = vid_de_d ? pattern : '0;
  end

  // State and output registers.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      mode_q        <= '0;
      solid_q       <= '0;
      vid_data_q    <= '0;
      vid_de_q      <= 1'b0;
      vid_hsync_q   <= ~HS_POL;
      vid_vsync_q   <= ~VS_POL;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      mode_q        <= mode_d;
      solid_q       <= solid_d;
      vid_data_q    <= vid_data_d;
      vid_de_q      <= vid_de_d;
      vid_hsync_q   <= vid_hsync_d;
      vid_vsync_q   <= vid_vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vid_data    = vid_data_q;
  assign vid_de      = vid_de_q;
  assign vid_hsync   = vid_hsync_q;
  assign vid_vsync   = vid_vsync_q;
  assign frame_start = frame_start_q;

endmodule
